sisc_fetch_unit: RTL and testbench

//  Datapath-side responder to the SISC control FSM. Consumes pc_rst, pc_sel, pc_write, br_sel and ir_load.

---
 rtl/sisc_fetch_unit_if.sv | 24 ++
 rtl/sisc_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_sisc_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the SISC fetch unit and imem.
// The fetch unit is the master; the memory model or controller is the slave.
interface sisc_fetch_unit_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns the PC and IR, fetches over a req/ack bus with a timeout,
// and evaluates branch conditions for the control FSM.
module sisc_fetch_unit #(
  parameter int PC_W     = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              pc_rst,
  input  logic              ir_load,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic [3:0]        stat,
  sisc_fetch_unit_if.master imem,
  output logic [PC_W-1:0]   pc_out,
  output logic [31:0]       ir_out,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic              fetch_busy,
  output logic              fetch_err,
  output logic              br_taken
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   addr_reg;
  logic [31:0]       ir_reg;
  logic              br_taken_reg;

  logic              fetch_start;
  logic              fetch_done;
  logic              fetch_timeout;
  logic              br_cond;
  logic              br_load;
  logic [PC_W-1:0]   imm;
  logic [PC_W-1:0]   br_target;

  // Immediate is the low half of the IR, widened by sign extension or cut down to PC_W.
  generate
    if (PC_W > 16) begin : g_imm_sext
      assign imm = {{(PC_W-16){ir_reg[15]}}, ir_reg[15:0]};
    end else begin : g_imm_trunc
      assign imm = ir_reg[PC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    fetch_start   = 1'b0;
    fetch_done    = 1'b0;
    fetch_timeout = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ir_load) begin
          state_next  = ST_WAIT;
          cnt_next    = '0;
          fetch_start = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem.imem_ack) begin
          state_next = ST_IDLE;
          fetch_done = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next    = ST_IDLE;
          fetch_timeout = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // pc_rst aborts any fetch activity on this edge, including a coincident ack.
    if (pc_rst) begin
      state_next    = ST_IDLE;
      fetch_start   = 1'b0;
      fetch_done    = 1'b0;
      fetch_timeout = 1'b0;
    end
  end

  always_comb begin
    br_cond = 1'b0;
    case (ir_reg[31:28])
      4'd4, 4'd5: br_cond = |(ir_reg[27:24] & stat);
      4'd6, 4'd7: br_cond = ~|(ir_reg[27:24] & stat);
      default:    br_cond = 1'b0;
    endcase
  end

  assign br_load   = pc_write & pc_sel & br_cond & ~pc_rst;
  assign br_target = br_sel ? imm : (pc_reg + imm);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_reg       <= '0;
      ir_reg       <= '0;
      addr_reg     <= '0;
      br_taken_reg <= 1'b0;
    end else begin
      br_taken_reg <= br_load;
      if (fetch_start)
        addr_reg <= pc_reg;
      if (fetch_done)
        ir_reg <= imem.imem_data;
      else if (fetch_timeout)
        ir_reg <= '0;
      // A branch load overrides the post-fetch increment on the same edge.
      if (pc_rst)
        pc_reg <= '0;
      else if (br_load)
        pc_reg <= br_target;
      else if (fetch_done)
        pc_reg <= pc_reg + PC_W'(1);
    end
  end

  assign imem.imem_req  = (state_reg == ST_WAIT);
  assign imem.imem_addr = addr_reg;
  assign fetch_busy     = (state_reg == ST_WAIT);
  assign fetch_err      = fetch_timeout;
  assign br_taken       = br_taken_reg;
  assign pc_out         = pc_reg;
  assign ir_out         = ir_reg;
  assign opcode         = ir_reg[31:28];
  assign mm             = ir_reg[27:24];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: a branch vector table plus hand-written
// sequences for reset, fetch latency, timeout and same-edge collisions.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_rst = 1'b0;
  logic        ir_load = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic [3:0]  stat = 4'd0;
  logic [15:0] pc_out;
  logic [31:0] ir_out;
  logic [3:0]  opcode, mm;
  logic        fetch_busy, fetch_err, br_taken;

  int n_cmp = 0;
  int n_bad = 0;

  sisc_fetch_unit_if #(.PC_W(16)) mem ();

  sisc_fetch_unit #(.PC_W(16), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .stat       (stat),
    .imem       (mem),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .opcode     (opcode),
    .mm         (mm),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .br_taken   (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [15:0] pc;
    logic [3:0]  stat;
    logic        br_sel;
    logic        pc_write;
    logic        pc_sel;
    logic [15:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after IR has loaded.
  task automatic do_fetch(input logic [31:0] data);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    mem.imem_ack  = 1'b1;
    mem.imem_data = data;
    @(negedge clk);
    mem.imem_ack = 1'b0;
  endtask

  // BNE with mm=0 is always taken, so an absolute branch plants any PC value.
  task automatic set_pc(input logic [15:0] val);
    do_fetch({16'h6000, val});
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    @(negedge clk);
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem.imem_ack  = 1'b0;
    mem.imem_data = 32'h0;

    vec[0]  = '{32'h5100_FFFD, 16'd10,   4'b0001, 1'b0, 1'b1, 1'b1, 16'd7,    1'b1};
    vec[1]  = '{32'h5100_FFFD, 16'd10,   4'b0000, 1'b0, 1'b1, 1'b1, 16'd10,   1'b0};
    vec[2]  = '{32'h6200_0040, 16'h0020, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1};
    vec[3]  = '{32'h6200_0002, 16'hFFFF, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1};
    vec[4]  = '{32'h6200_0040, 16'h0020, 4'b0010, 1'b1, 1'b1, 1'b1, 16'h0020, 1'b0};
    vec[5]  = '{32'h4800_1234, 16'h0300, 4'b1000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1};
    vec[6]  = '{32'h7400_0005, 16'h0100, 4'b0001, 1'b0, 1'b1, 1'b1, 16'h0105, 1'b1};
    vec[7]  = '{32'h3F00_0010, 16'h0200, 4'b1111, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0};
    vec[8]  = '{32'h4100_0077, 16'h0020, 4'b0001, 1'b1, 1'b1, 1'b0, 16'h0020, 1'b0};
    vec[9]  = '{32'h4100_0077, 16'h0020, 4'b0001, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b0};
    vec[10] = '{32'h4100_8000, 16'h0005, 4'b0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1};

    // Power-on reset
    @(negedge clk);
    chk("reset_pc", 32'(pc_out), 32'h0);
    chk("reset_ir", ir_out, 32'h0);
    chk("reset_req", 32'(mem.imem_req), 32'h0);
    chk("reset_busy", 32'(fetch_busy), 32'h0);
    chk("reset_err", 32'(fetch_err), 32'h0);
    chk("reset_brt", 32'(br_taken), 32'h0);
    rst_f = 1'b1;
    @(negedge clk);
    $display("reset: pc=%h ir=%h", pc_out, ir_out);

    // Fetch with ack on first WAIT cycle
    set_pc(16'd3);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    chk("lat_req", 32'(mem.imem_req), 32'h1);
    chk("lat_busy", 32'(fetch_busy), 32'h1);
    chk("lat_addr", 32'(mem.imem_addr), 32'h3);
    chk("lat_ir_early", ir_out, 32'h6000_0003);
    mem.imem_ack = 1'b1; mem.imem_data = 32'h1000_0005;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    chk("lat_ir", ir_out, 32'h1000_0005);
    chk("lat_opcode", 32'(opcode), 32'h1);
    chk("lat_mm", 32'(mm), 32'h0);
    chk("lat_pc", 32'(pc_out), 32'h4);
    chk("lat_req_drop", 32'(mem.imem_req), 32'h0);
    $display("fetch: ir=%h opcode=%h pc=%h", ir_out, opcode, pc_out);

    // Timeout: no ack for MAX_WAIT cycles
    set_pc(16'h0030);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("to_err_c%0d", c), 32'(fetch_err), (c == 8) ? 32'h1 : 32'h0);
      chk($sformatf("to_req_c%0d", c), 32'(mem.imem_req), 32'h1);
      @(negedge clk);
    end
    chk("to_err_after", 32'(fetch_err), 32'h0);
    chk("to_req_after", 32'(mem.imem_req), 32'h0);
    chk("to_ir", ir_out, 32'h0);
    chk("to_pc", 32'(pc_out), 32'h0030);
    $display("timeout: ir=%h pc=%h", ir_out, pc_out);

    // Branch vector table
    for (int i = 0; i < 11; i++) begin
      set_pc(vec[i].pc - 16'd1);
      do_fetch(vec[i].ir);
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vec[i].ir[31:28]));
      chk($sformatf("v%0d_mm", i), 32'(mm), 32'(vec[i].ir[27:24]));
      chk($sformatf("v%0d_pc_pre", i), 32'(pc_out), 32'(vec[i].pc));
      stat = vec[i].stat; br_sel = vec[i].br_sel;
      pc_write = vec[i].pc_write; pc_sel = vec[i].pc_sel;
      @(negedge clk);
      pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
      chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vec[i].exp_pc));
      chk($sformatf("v%0d_brt", i), 32'(br_taken), 32'(vec[i].exp_taken));
      @(negedge clk);
      chk($sformatf("v%0d_brt_drop", i), 32'(br_taken), 32'h0);
      $display("vec %0d: ir=%h stat=%b pc=%h br_taken_exp=%0d", i, vec[i].ir, vec[i].stat, pc_out, vec[i].exp_taken);
    end

    // Mid-fetch branch keeps imem_addr; branch + ack on same edge drops increment
    set_pc(16'h0050);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    @(negedge clk);
    chk("col_pc_mid", 32'(pc_out), 32'h00A0);
    chk("col_addr_mid", 32'(mem.imem_addr), 32'h0050);
    chk("col_brt_mid", 32'(br_taken), 32'h1);
    chk("col_req_mid", 32'(mem.imem_req), 32'h1);
    mem.imem_ack = 1'b1; mem.imem_data = 32'hABCD_0123;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    pc_write = 1'b0; pc_sel = 1'b0;
    chk("col_ir", ir_out, 32'hABCD_0123);
    chk("col_pc", 32'(pc_out), 32'h00F0);
    chk("col_brt", 32'(br_taken), 32'h1);
    $display("collision: ir=%h pc=%h", ir_out, pc_out);

    // pc_rst during WAIT, then a late ack
    set_pc(16'h0044);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    pc_rst = 1'b1;
    @(negedge clk);
    pc_rst = 1'b0;
    chk("pcrst_pc", 32'(pc_out), 32'h0);
    chk("pcrst_req", 32'(mem.imem_req), 32'h0);
    chk("pcrst_ir", ir_out, 32'h6000_0044);
    mem.imem_ack = 1'b1; mem.imem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    chk("pcrst_late_ir", ir_out, 32'h6000_0044);
    chk("pcrst_late_pc", 32'(pc_out), 32'h0);
    $display("pc_rst: ir=%h pc=%h", ir_out, pc_out);

    // Asynchronous reset mid-WAIT, then a late ack
    set_pc(16'h0022);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    chk("arst_req_pre", 32'(mem.imem_req), 32'h1);
    #2 rst_f = 1'b0;
    #1;
    chk("arst_req", 32'(mem.imem_req), 32'h0);
    chk("arst_busy", 32'(fetch_busy), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_ir", ir_out, 32'h0);
    @(negedge clk);
    rst_f = 1'b1;
    mem.imem_ack = 1'b1; mem.imem_data = 32'h1234_5678;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    chk("arst_late_ir", ir_out, 32'h0);
    chk("arst_late_pc", 32'(pc_out), 32'h0);
    chk("arst_late_req", 32'(mem.imem_req), 32'h0);
    $display("async reset: ir=%h pc=%h", ir_out, pc_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
